sobel_grid_filter: RTL and testbench

//  Consumes the 3x3 RGB window emitted by the 3-line tap buffer and computes a Sobel

---
 rtl/sobel_pkg.sv | 38 +++
 rtl/sobel_grid_filter_if.sv | 23 ++
 rtl/sobel_luma.sv | 16 +
 rtl/sobel_grid_filter.sv | 129 ++++++++++++
 tb/tb_sobel_grid_filter.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared constants, tap indices and channel extraction for the Sobel edge path.
package sobel_pkg;

  localparam int unsigned PIX_W  = 30;
  localparam int unsigned LUMA_W = 10;
  localparam int unsigned SUM_W  = 12;
  localparam int unsigned GRAD_W = 13;
  localparam logic [LUMA_W-1:0] MAG_MAX = 10'd1023;

  // p[8:6] newest line, p[2:0] oldest line
  localparam int unsigned P0 = 0;
  localparam int unsigned P1 = 1;
  localparam int unsigned P2 = 2;
  localparam int unsigned P3 = 3;
  localparam int unsigned P4 = 4;
  localparam int unsigned P5 = 5;
  localparam int unsigned P6 = 6;
  localparam int unsigned P7 = 7;
  localparam int unsigned P8 = 8;
  localparam int unsigned NTAPS = 9;

  typedef enum logic [1:0] {
    CH_B = 2'd0,
    CH_G = 2'd1,
    CH_R = 2'd2
  } chan_e;

  function automatic logic [LUMA_W-1:0] chan(input logic [PIX_W-1:0] pix, input chan_e c);
    logic [LUMA_W-1:0] v;
    case (c)
      CH_R:    v = pix[29:20];
      CH_G:    v = pix[19:10];
      default: v = pix[9:0];
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sobel_grid_filter_if.sv
// Window-in / edge-pixel-out signal bundle between line buffer, filter and frame writer.
interface sobel_grid_filter_if;
  import sobel_pkg::*;

  logic                    clken;
  logic [NTAPS*PIX_W-1:0]  iGrid;
  logic                    iSof;
  logic [LUMA_W-1:0]       iThreshold;
  logic [PIX_W-1:0]        oPixel;
  logic                    oEdge;
  logic                    oValid;

  modport master (
    output clken, iGrid, iSof, iThreshold,
    input  oPixel, oEdge, oValid
  );

  modport slave (
    input  clken, iGrid, iSof, iThreshold,
    output oPixel, oEdge, oValid
  );

endinterface

// File: rtl/sobel_luma.sv
// Combinational RGB to 10-bit luma: y = (R + 2G + B) >> 2.
module sobel_luma
  import sobel_pkg::*;
(
  input  logic [PIX_W-1:0]  pix,
  output logic [LUMA_W-1:0] y
);

  logic [SUM_W-1:0] sum;

  always_comb begin
    sum = {2'b00, chan(pix, CH_R)} + {1'b0, chan(pix, CH_G), 1'b0} + {2'b00, chan(pix, CH_B)};
    y   = sum[SUM_W-1:2];
  end

endmodule

// File: rtl/sobel_grid_filter.sv
// Three-stage Sobel magnitude filter: luma + position tag, gradients, saturate/mask/threshold.
module sobel_grid_filter
  import sobel_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic clock,
  input  logic reset_n,
  sobel_grid_filter_if.slave bus
);

  localparam int unsigned COL_W = $clog2(H_ACTIVE);
  localparam int unsigned ROW_W = $clog2(V_ACTIVE);

  // Position counters and S1 tag
  logic [COL_W-1:0] col_q, col_d, tag_col_q, tag_col_d;
  logic [ROW_W-1:0] row_q, row_d, tag_row_q, tag_row_d;

  // S1
  logic [LUMA_W-1:0] luma_d [NTAPS];
  logic [LUMA_W-1:0] luma_q [NTAPS];
  logic              v1_q, v1_d;

  // S2
  logic signed [GRAD_W-1:0] gx_q, gx_d, gy_q, gy_d;
  logic                     v2_q, v2_d, mask_q, mask_d;
  logic [SUM_W-1:0]         gx_pos, gx_neg, gy_pos, gy_neg;

  // S3
  logic [PIX_W-1:0]  pixel_q, pixel_d;
  logic              edge_q, edge_d, valid_q, valid_d;
  logic [GRAD_W-1:0] ax, ay, mag13;
  logic [LUMA_W-1:0] mag;

  for (genvar k = 0; k < NTAPS; k++) begin : g_luma
    sobel_luma u_luma (
      .pix (bus.iGrid[k*PIX_W +: PIX_W]),
      .y   (luma_d[k])
    );
  end

  // Window is tagged with the pre-increment position; iSof forces (0,0).
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    tag_col_d = col_q;
    tag_row_d = row_q;
    v1_d      = bus.clken;
    if (bus.clken) begin
      if (bus.iSof) begin
        tag_col_d = '0;
        tag_row_d = '0;
        col_d     = COL_W'(1);
        row_d     = '0;
      end else if (col_q == COL_W'(H_ACTIVE - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(V_ACTIVE - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    gx_pos = {2'b00, luma_q[P6]} + {1'b0, luma_q[P3], 1'b0} + {2'b00, luma_q[P0]};
    gx_neg = {2'b00, luma_q[P8]} + {1'b0, luma_q[P5], 1'b0} + {2'b00, luma_q[P2]};
    gy_pos = {2'b00, luma_q[P8]} + {1'b0, luma_q[P7], 1'b0} + {2'b00, luma_q[P6]};
    gy_neg = {2'b00, luma_q[P2]} + {1'b0, luma_q[P1], 1'b0} + {2'b00, luma_q[P0]};
    gx_d   = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
    gy_d   = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
    v2_d   = v1_q;
    mask_d = (tag_col_q < COL_W'(2)) || (tag_row_q < ROW_W'(2));
  end

  always_comb begin
    ax      = gx_q[GRAD_W-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    ay      = gy_q[GRAD_W-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    mag13   = ax + ay;
    mag     = (mag13 > GRAD_W'(MAG_MAX)) ? MAG_MAX : mag13[LUMA_W-1:0];
    if (mask_q) begin
      mag = '0;
    end
    edge_d  = !mask_q && (mag > bus.iThreshold);
    pixel_d = {mag, mag, mag};
    valid_d = v2_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_q     <= '0;
      row_q     <= '0;
      tag_col_q <= '0;
      tag_row_q <= '0;
      v1_q      <= 1'b0;
      for (int unsigned i = 0; i < NTAPS; i++) begin
        luma_q[i] <= '0;
      end
      gx_q      <= '0;
      gy_q      <= '0;
      v2_q      <= 1'b0;
      mask_q    <= 1'b0;
      pixel_q   <= '0;
      edge_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      tag_col_q <= tag_col_d;
      tag_row_q <= tag_row_d;
      v1_q      <= v1_d;
      for (int unsigned i = 0; i < NTAPS; i++) begin
        luma_q[i] <= luma_d[i];
      end
      gx_q      <= gx_d;
      gy_q      <= gy_d;
      v2_q      <= v2_d;
      mask_q    <= mask_d;
      pixel_q   <= pixel_d;
      edge_q    <= edge_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.oPixel = pixel_q;
  assign bus.oEdge  = edge_q;
  assign bus.oValid = valid_q;

endmodule

// File: tb/tb_sobel_grid_filter.sv
// Directed bench for sobel_grid_filter: expected outputs queued with the three-clock latency.
module tb_sobel_grid_filter;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  sobel_grid_filter_if bus ();

  sobel_grid_filter #(.H_ACTIVE(640), .V_ACTIVE(480)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        ev [3];
  logic [29:0] ep [3];
  logic        ee [3];
  string       et [3];

  function automatic logic [29:0] gray(input logic [9:0] v);
    return {v, v, v};
  endfunction

  function automatic logic [269:0] grid9(input logic [9:0] a8, a7, a6, a5, a4, a3, a2, a1, a0);
    return {gray(a8), gray(a7), gray(a6), gray(a5), gray(a4), gray(a3), gray(a2), gray(a1), gray(a0)};
  endfunction

  task automatic cyc(input logic ck, input logic sof, input logic [269:0] g,
                     input logic [9:0] xm, input logic xe, input string tg);
    @(negedge clk);
    checks++;
    assert (bus.oValid === ev[2]) else begin
      errors++;
      $error("FAIL %s oValid got %b exp %b", et[2], bus.oValid, ev[2]);
    end
    if (ev[2]) begin
      checks++;
      assert (bus.oPixel === ep[2]) else begin
        errors++;
        $error("FAIL %s oPixel got %h exp %h", et[2], bus.oPixel, ep[2]);
      end
      checks++;
      assert (bus.oEdge === ee[2]) else begin
        errors++;
        $error("FAIL %s oEdge got %b exp %b", et[2], bus.oEdge, ee[2]);
      end
    end
    for (int i = 2; i > 0; i--) begin
      ev[i] = ev[i-1];
      ep[i] = ep[i-1];
      ee[i] = ee[i-1];
      et[i] = et[i-1];
    end
    ev[0] = ck;
    ep[0] = {xm, xm, xm};
    ee[0] = xe;
    et[0] = tg;
    bus.clken = ck;
    bus.iSof  = sof;
    bus.iGrid = g;
  endtask

  task automatic check_zero(input string tg);
    checks++;
    assert (bus.oValid === 1'b0) else begin
      errors++;
      $error("FAIL %s oValid got %b exp 0", tg, bus.oValid);
    end
    checks++;
    assert (bus.oPixel === 30'd0) else begin
      errors++;
      $error("FAIL %s oPixel got %h exp 0", tg, bus.oPixel);
    end
    checks++;
    assert (bus.oEdge === 1'b0) else begin
      errors++;
      $error("FAIL %s oEdge got %b exp 0", tg, bus.oEdge);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 10'd0, 1'b0, "idle");
  endtask

  localparam logic [9:0] W = 10'd1023;

  logic [269:0] w_flat, w_vert, w_vneg, w_horz, w_mix, w_t100, w_sat, w_1020;
  logic         masked;

  initial begin
    w_flat = grid9(W, W, W, W, W, W, W, W, W);
    w_vert = grid9(0, W, W, 0, W, W, 0, W, W);
    w_vneg = grid9(W, W, 0, W, W, 0, W, W, 0);
    w_horz = grid9(W, W, W, 0, 0, 0, 0, 0, 0);
    w_mix  = grid9(500, 520, 500, 510, 500, 500, 500, 500, 500);
    w_t100 = grid9(100, 100, 125, 100, 100, 125, 100, 100, 125);
    w_sat  = grid9(100, 100, 356, 100, 100, 356, 100, 100, 356);
    w_1020 = grid9(100, 100, 355, 100, 100, 355, 100, 100, 355);
    for (int i = 0; i < 3; i++) begin
      ev[i] = 1'b0;
      ep[i] = '0;
      ee[i] = 1'b0;
      et[i] = "none";
    end
    bus.clken      = 1'b0;
    bus.iSof       = 1'b0;
    bus.iGrid      = '0;
    bus.iThreshold = 10'd100;

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Border masking across rows 0-1 and the first two columns of each row
    for (int i = 0; i < 1300; i++) begin
      masked = ((i % 640) < 2) || ((i / 640) < 2);
      cyc(1'b1, (i == 0), w_vert, masked ? 10'd0 : W, !masked, $sformatf("border%0d", i));
    end

    cyc(1'b1, 1'b0, w_flat, 10'd0,    1'b0, "flat");
    cyc(1'b1, 1'b0, w_vert, W,        1'b1, "vert_edge");
    cyc(1'b1, 1'b0, w_vneg, W,        1'b1, "vert_neg");
    cyc(1'b1, 1'b0, w_horz, W,        1'b1, "horz_edge");
    cyc(1'b1, 1'b0, w_mix,  10'd60,   1'b0, "mixed_60");
    cyc(1'b1, 1'b0, w_sat,  W,        1'b1, "sat_1024");
    cyc(1'b1, 1'b0, w_1020, 10'd1020, 1'b1, "mag_1020");
    idle(3);

    cyc(1'b1, 1'b0, w_t100, 10'd100, 1'b0, "thr100_eq");
    idle(3);
    bus.iThreshold = 10'd99;
    cyc(1'b1, 1'b0, w_t100, 10'd100, 1'b1, "thr99_gt");
    idle(3);
    bus.iThreshold = 10'd100;

    // clken 1,0,1,1,0 with an unqualified iSof in the gap
    cyc(1'b1, 1'b0, w_vert, W,      1'b1, "pat0");
    cyc(1'b0, 1'b1, w_flat, 10'd0,  1'b0, "pat1_gap");
    cyc(1'b1, 1'b0, w_mix,  10'd60, 1'b0, "pat2");
    cyc(1'b1, 1'b0, w_horz, W,      1'b1, "pat3");
    cyc(1'b0, 1'b0, w_vert, 10'd0,  1'b0, "pat4_gap");
    idle(3);

    // Reset with two windows in flight
    cyc(1'b1, 1'b0, w_vert, W, 1'b1, "inflight_a");
    cyc(1'b1, 1'b0, w_vert, W, 1'b1, "inflight_b");
    cyc(1'b0, 1'b0, '0, 10'd0, 1'b0, "inflight_gap");
    #1 rst_n = 1'b0;
    #1 check_zero("reset_midframe");
    for (int i = 0; i < 3; i++) ev[i] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, w_vert, 10'd0, 1'b0, "post_reset_00");
    cyc(1'b1, 1'b0, w_vert, 10'd0, 1'b0, "post_reset_10");
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
